// File: rtl/alu.sv
// 8-bit Harvard processor: A/B/PC/RET registers, synchronous instruction ROM, tri-state data bus.
// Build option: define ALU_MUL_EN to give ALU op 2 an 8x8 multiplier; otherwise op 2 passes A.
module alu (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    output logic [7:0] ROM_ADDRESS,
    input  logic [7:0] ROM_DATA,
    input  logic [1:0] BUS_INTERRUPTS_RAISE,
    output logic [1:0] BUS_INTERRUPTS_ACK
);
    localparam int unsigned DW = 8;

    localparam logic [3:0] OP_LD_A   = 4'h0;
    localparam logic [3:0] OP_LD_B   = 4'h1;
    localparam logic [3:0] OP_ST_A   = 4'h2;
    localparam logic [3:0] OP_ST_B   = 4'h3;
    localparam logic [3:0] OP_ALU_A  = 4'h4;
    localparam logic [3:0] OP_ALU_B  = 4'h5;
    localparam logic [3:0] OP_BRANCH = 4'h6;
    localparam logic [3:0] OP_GOTO   = 4'h7;
    localparam logic [3:0] OP_IDLE   = 4'h8;
    localparam logic [3:0] OP_CALL   = 4'h9;
    localparam logic [3:0] OP_RET    = 4'hA;
    localparam logic [3:0] OP_DEREF_A = 4'hB;
    localparam logic [3:0] OP_DEREF_B = 4'hC;

    typedef enum logic [3:0] {
        FETCH, DECODE, OPND, EXEC, DEREF, LOAD_WAIT, LOAD_CAP, IDLE, INT_WAIT, INT_LOAD
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] pc, pc_nxt, a, a_nxt, b, b_nxt, ret, ret_nxt;
    logic [DW-1:0] ir, ir_nxt, opnd, opnd_nxt, wdata, wdata_nxt;
    logic [DW-1:0] rom_nxt, bus_addr_nxt, next_pc, alu_res;
    logic          bus_we_nxt, take;
    logic [1:0]    ack_nxt;

    assign BUS_DATA = BUS_WE ? wdata : 8'hzz;

    // ALU result for the operation held in the instruction register
    always_comb begin
        alu_res = a;
        case (ir[7:4])
            4'h0: alu_res = a + b;
            4'h1: alu_res = a - b;
`ifdef ALU_MUL_EN
            4'h2: alu_res = a * b;
`endif
            4'h3: alu_res = a << 1;
            4'h4: alu_res = a >> 1;
            4'h5: alu_res = a + 8'd1;
            4'h6: alu_res = b + 8'd1;
            4'h7: alu_res = a - 8'd1;
            4'h8: alu_res = b - 8'd1;
            4'h9: alu_res = {7'd0, a == b};
            4'hA: alu_res = {7'd0, a > b};
            4'hB: alu_res = {7'd0, a < b};
            default: alu_res = a;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (ir[7:4])
            4'h0: take = (a == b);
            4'h1: take = (a > b);
            4'h2: take = (a < b);
            default: take = 1'b0;
        endcase
    end

    // ROM_ADDRESS always points at the byte the ROM must sample on the coming edge
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        a_nxt        = a;
        b_nxt        = b;
        ret_nxt      = ret;
        ir_nxt       = ir;
        opnd_nxt     = opnd;
        wdata_nxt    = wdata;
        rom_nxt      = ROM_ADDRESS;
        bus_addr_nxt = BUS_ADDR;
        bus_we_nxt   = 1'b0;
        ack_nxt      = 2'b00;
        next_pc      = pc + 8'd1;
        case (state)
            FETCH: begin
                rom_nxt   = pc + 8'd1;
                state_nxt = DECODE;
            end
            DECODE: begin
                ir_nxt = ROM_DATA;
                case (ROM_DATA[3:0])
                    OP_LD_A, OP_LD_B, OP_ST_A, OP_ST_B,
                    OP_BRANCH, OP_GOTO, OP_CALL: state_nxt = OPND;
                    OP_IDLE:                     state_nxt = IDLE;
                    OP_DEREF_A, OP_DEREF_B:      state_nxt = DEREF;
                    default:                     state_nxt = EXEC;
                endcase
            end
            OPND: begin
                opnd_nxt  = ROM_DATA;
                state_nxt = EXEC;
                case (ir[3:0])
                    OP_LD_A, OP_LD_B: begin
                        bus_addr_nxt = ROM_DATA;
                        state_nxt    = LOAD_WAIT;
                    end
                    OP_ST_A, OP_ST_B: begin
                        bus_addr_nxt = ROM_DATA;
                        bus_we_nxt   = 1'b1;
                        wdata_nxt    = (ir[3:0] == OP_ST_B) ? b : a;
                    end
                    default: ;
                endcase
            end
            EXEC: begin
                case (ir[3:0])
                    OP_ALU_A:         a_nxt = alu_res;
                    OP_ALU_B:         b_nxt = alu_res;
                    OP_ST_A, OP_ST_B: next_pc = pc + 8'd2;
                    OP_BRANCH:        next_pc = take ? opnd : pc + 8'd2;
                    OP_GOTO:          next_pc = opnd;
                    OP_CALL: begin
                        ret_nxt = pc + 8'd2;
                        next_pc = opnd;
                    end
                    OP_RET:           next_pc = ret;
                    default: ;
                endcase
                pc_nxt    = next_pc;
                rom_nxt   = next_pc;
                state_nxt = FETCH;
            end
            DEREF: begin
                bus_addr_nxt = (ir[3:0] == OP_DEREF_A) ? a : b;
                state_nxt    = LOAD_WAIT;
            end
            LOAD_WAIT: state_nxt = LOAD_CAP;
            LOAD_CAP: begin
                if (ir[3:0] == OP_LD_A || ir[3:0] == OP_DEREF_A) a_nxt = BUS_DATA;
                else b_nxt = BUS_DATA;
                if (ir[3:0] == OP_LD_A || ir[3:0] == OP_LD_B) next_pc = pc + 8'd2;
                pc_nxt    = next_pc;
                rom_nxt   = next_pc;
                state_nxt = FETCH;
            end
            IDLE: begin
                if (BUS_INTERRUPTS_RAISE[0]) begin
                    ack_nxt   = 2'b01;
                    ret_nxt   = pc + 8'd1;
                    rom_nxt   = 8'hFF;
                    state_nxt = INT_WAIT;
                end else if (BUS_INTERRUPTS_RAISE[1]) begin
                    ack_nxt   = 2'b10;
                    ret_nxt   = pc + 8'd1;
                    rom_nxt   = 8'hFE;
                    state_nxt = INT_WAIT;
                end
            end
            INT_WAIT: state_nxt = INT_LOAD;
            INT_LOAD: begin
                pc_nxt    = ROM_DATA;
                rom_nxt   = ROM_DATA;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state              <= FETCH;
            pc                 <= '0;
            a                  <= '0;
            b                  <= '0;
            ret                <= '0;
            ir                 <= '0;
            opnd               <= '0;
            wdata              <= '0;
            ROM_ADDRESS        <= '0;
            BUS_ADDR           <= 8'hFF;
            BUS_WE             <= 1'b0;
            BUS_INTERRUPTS_ACK <= 2'b00;
        end else begin
            state              <= state_nxt;
            pc                 <= pc_nxt;
            a                  <= a_nxt;
            b                  <= b_nxt;
            ret                <= ret_nxt;
            ir                 <= ir_nxt;
            opnd               <= opnd_nxt;
            wdata              <= wdata_nxt;
            ROM_ADDRESS        <= rom_nxt;
            BUS_ADDR           <= bus_addr_nxt;
            BUS_WE             <= bus_we_nxt;
            BUS_INTERRUPTS_ACK <= ack_nxt;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: small ROM programs make stores/acks whose cycle, address and data are predicted.
module tb_alu;
    logic       CLK = 1'b0;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR, ROM_ADDRESS, ROM_DATA;
    logic       BUS_WE;
    logic [1:0] raise, ack;

    always #5 CLK = ~CLK;

    alu dut (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
        .ROM_ADDRESS(ROM_ADDRESS), .ROM_DATA(ROM_DATA),
        .BUS_INTERRUPTS_RAISE(raise), .BUS_INTERRUPTS_ACK(ack)
    );

    logic [7:0] rom [256];
    logic [7:0] mem [256];
    logic [7:0] mem_init [256];
    logic [7:0] rd;
    logic [7:0] pq [$];
    logic       mem_load;
    int         wr_cnt = 0;
    int         cyc;
    int         vectors = 0;
    int         miscompares = 0;
    logic       prev_we;

    typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } st_t;
    typedef struct { int cyc; logic [1:0] ack; } ak_t;
    st_t sq [$];
    ak_t aq [$];

    // synchronous ROM and data memory, one cycle read latency each
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDRESS];
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_init[i];
        end else if (BUS_WE) begin
            mem[BUS_ADDR] <= BUS_DATA;
            wr_cnt <= wr_cnt + 1;
        end
        rd <= mem[BUS_ADDR];
    end
    assign BUS_DATA = BUS_WE ? 8'hzz : rd;

    always @(posedge CLK or negedge RESET)
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;

    // monitor: every store strobe and ack pulse must match the head of its queue
    always @(negedge CLK) begin
        if (RESET) begin
            if (BUS_WE) begin
                vectors++;
                if (sq.size() == 0) begin
                    miscompares++;
                    $display("FAIL store_unexpected: cyc=%0d addr=%h data=%h", cyc, BUS_ADDR, BUS_DATA);
                end else begin
                    st_t e;
                    e = sq.pop_front();
                    if (e.cyc != cyc || e.addr !== BUS_ADDR || e.data !== BUS_DATA || prev_we) begin
                        miscompares++;
                        $display("FAIL store: got cyc=%0d addr=%h data=%h prev_we=%b, want cyc=%0d addr=%h data=%h prev_we=0",
                                 cyc, BUS_ADDR, BUS_DATA, prev_we, e.cyc, e.addr, e.data);
                    end
                end
            end
            if (ack != 2'b00) begin
                vectors++;
                if (aq.size() == 0) begin
                    miscompares++;
                    $display("FAIL ack_unexpected: cyc=%0d ack=%b", cyc, ack);
                end else begin
                    ak_t k;
                    k = aq.pop_front();
                    if (k.cyc != cyc || k.ack !== ack) begin
                        miscompares++;
                        $display("FAIL ack: got cyc=%0d ack=%b, want cyc=%0d ack=%b", cyc, ack, k.cyc, k.ack);
                    end
                end
            end
            prev_we = BUS_WE;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic exp_st(input int c, input logic [7:0] ad, input logic [7:0] d);
        st_t e;
        e.cyc = c; e.addr = ad; e.data = d;
        sq.push_back(e);
    endtask

    task automatic exp_ack(input int c, input logic [1:0] v);
        ak_t k;
        k.cyc = c; k.ack = v;
        aq.push_back(k);
    endtask

    task automatic clear_env();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h0D;
            mem_init[i] = 8'h00;
        end
        sq.delete();
        aq.delete();
        raise = 2'b00;
    endtask

    task automatic place(input logic [7:0] base);
        for (int i = 0; i < pq.size(); i++) rom[base + 8'(i)] = pq[i];
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        mem_load = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        mem_load = 1'b0;
        RESET = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int k = 0;
        while (cyc != n && k < 500) begin
            @(negedge CLK);
            k++;
        end
        if (cyc != n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_cyc: got cyc=%0d want %0d", cyc, n);
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sq.size() != 0 || aq.size() != 0) && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (sq.size() != 0 || aq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d stores/%0d acks outstanding want 0", name, sq.size(), aq.size());
            sq.delete();
            aq.delete();
        end
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        int w0;
        RESET = 1'b0;
        raise = 2'b00;
        mem_load = 1'b0;

        // load/load/add wraps to 01, then store; also reset-state checks
        clear_env();
        pq = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h04, 8'h02, 8'h80, 8'h07, 8'h07};
        place(8'h00);
        mem_init[8'h10] = 8'h07;
        mem_init[8'h11] = 8'hFA;
        mem_init[8'hFF] = 8'h3C;
        exp_st(16, 8'h80, 8'h01);
        do_reset();
        #1;
        chk("rst_rom_addr", 32'(ROM_ADDRESS), 32'h00);
        chk("rst_bus_we", 32'(BUS_WE), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_bus_addr", 32'(BUS_ADDR), 32'hFF);
        chk("rst_bus_hiz", 32'(BUS_DATA), 32'h3C);
        wait_drain("add_wrap");

        // stores, subtract, compare, deref, shift
        clear_env();
        pq = '{8'h00, 8'h20, 8'h02, 8'hC0, 8'h01, 8'h21, 8'h14, 8'h02, 8'hC1, 8'hA4, 8'h02, 8'hC2,
               8'h0B, 8'h02, 8'hC3, 8'h35, 8'h03, 8'hC4, 8'h0C, 8'h03, 8'hC5, 8'h07, 8'h15};
        place(8'h00);
        mem_init[8'h20] = 8'h5A;
        mem_init[8'h21] = 8'h03;
        mem_init[8'h01] = 8'hE7;
        mem_init[8'hCE] = 8'h99;
        exp_st(8,  8'hC0, 8'h5A);
        exp_st(20, 8'hC1, 8'h57);
        exp_st(27, 8'hC2, 8'h01);
        exp_st(36, 8'hC3, 8'hE7);
        exp_st(43, 8'hC4, 8'hCE);
        exp_st(52, 8'hC5, 8'h99);
        do_reset();
        wait_drain("ops");

        // branches not taken / taken, call, return, inc/dec, shift right
        clear_env();
        pq = '{8'h00, 8'h30, 8'h01, 8'h31, 8'h26, 8'h40, 8'h16, 8'h50, 8'h36, 8'h90, 8'h06, 8'h60};
        place(8'h00);
        pq = '{8'h64, 8'h09, 8'h70, 8'h74, 8'h84, 8'h02, 8'hD1, 8'h44, 8'h02, 8'hD2, 8'h07, 8'h6A};
        place(8'h60);
        pq = '{8'h02, 8'hD0, 8'h0A};
        place(8'h70);
        mem_init[8'h30] = 8'h09;
        mem_init[8'h31] = 8'h09;
        exp_st(36, 8'hD0, 8'h0A);
        exp_st(49, 8'hD1, 8'h08);
        exp_st(56, 8'hD2, 8'h04);
        do_reset();
        wait_drain("flow");

        // goto FF, no-op there, PC wraps back to 00
        clear_env();
        pq = '{8'h02, 8'hE0, 8'h54, 8'h07, 8'hFF};
        place(8'h00);
        rom[8'hFF] = 8'h0D;
        exp_st(3,  8'hE0, 8'h00);
        exp_st(17, 8'hE0, 8'h01);
        do_reset();
        wait_drain("pc_wrap");

        // ALU op 2: product low byte with multiplier, pass A without; op F passes A
        clear_env();
        pq = '{8'h00, 8'h30, 8'h01, 8'h31, 8'h24, 8'h02, 8'hE1, 8'hF5, 8'h03, 8'hE2, 8'h07, 8'h0A};
        place(8'h00);
        mem_init[8'h30] = 8'h05;
        mem_init[8'h31] = 8'h06;
`ifdef ALU_MUL_EN
        exp_st(16, 8'hE1, 8'h1E);
        exp_st(23, 8'hE2, 8'h1E);
`else
        exp_st(16, 8'hE1, 8'h05);
        exp_st(23, 8'hE2, 8'h05);
`endif
        do_reset();
        wait_drain("mul");

        // idle, simultaneous requests (bit 0 wins), return to post-idle PC, then request 1
        clear_env();
        pq = '{8'h08, 8'h02, 8'hE6, 8'h08};
        place(8'h00);
        pq = '{8'h02, 8'hE5, 8'h54, 8'h0A};
        place(8'h40);
        pq = '{8'h02, 8'hE7, 8'h07, 8'h52};
        place(8'h50);
        rom[8'hFF] = 8'h40;
        rom[8'hFE] = 8'h50;
        exp_ack(6, 2'b01);
        exp_st(11, 8'hE5, 8'h00);
        exp_st(21, 8'hE6, 8'h01);
        exp_ack(25, 2'b10);
        exp_st(30, 8'hE7, 8'h01);
        do_reset();
        wait_cyc(5);
        raise = 2'b11;
        wait_cyc(20);
        raise = 2'b10;
        wait_drain("irq");
        raise = 2'b00;

        // reset during the store strobe: write must not land
        clear_env();
        pq = '{8'h02, 8'hE8, 8'h07, 8'h02};
        place(8'h00);
        mem_init[8'hE8] = 8'h11;
        exp_st(3, 8'hE8, 8'h00);
        do_reset();
        wait_cyc(3);
        #1;
        RESET = 1'b0;
        w0 = wr_cnt;
        #1;
        chk("abort_we", 32'(BUS_WE), 32'h0);
        chk("abort_bus_addr", 32'(BUS_ADDR), 32'hFF);
        chk("abort_rom_addr", 32'(ROM_ADDRESS), 32'h00);
        @(posedge CLK);
        #1;
        chk("abort_no_write", 32'(wr_cnt), 32'(w0));
        chk("abort_mem", 32'(mem[8'hE8]), 32'h11);
        chk("abort_queue", 32'(sq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-low reset; RESET=0 forces reset state immediately.
REQ-003 BUS_DATA  inout  8  shared data bus; driven only while BUS_WE=1, high-Z otherwise.
REQ-004 BUS_ADDR  output  8  data-bus address.
REQ-005 BUS_WE  output  1  data-bus write strobe, one cycle per store.
REQ-006 ROM_ADDRESS  output  8  instruction ROM address.
REQ-007 ROM_DATA  input  8  instruction ROM data; synchronous ROM, valid one cycle after ROM_ADDRESS.
REQ-008 BUS_INTERRUPTS_RAISE  input  2  interrupt requests, level-sensitive.
REQ-009 BUS_INTERRUPTS_ACK  output  2  interrupt acknowledge, one-cycle pulse per serviced request.

Function
REQ-010 Block SHALL be an 8-bit Harvard processor with registers A, B, PC, and one return register RET.
REQ-011 Instruction byte: [3:0] opcode, [7:4] ALU operation or branch condition; opcodes 0,1,2,3,6,7,9 SHALL take a second ROM byte as the address operand.
REQ-012 Opcodes: 0 A<=mem[op]; 1 B<=mem[op]; 2 mem[op]<=A; 3 mem[op]<=B; 4 A<=alu; 5 B<=alu; 6 branch to op if condition; 7 goto op; 8 idle; 9 call op (RET<=next PC); A return (PC<=RET); B A<=mem[A]; C B<=mem[B]; D-F no-op.
REQ-013 ALU ops: 0 A+B, 1 A-B, 2 A*B low 8 bits, 3 A<<1, 4 A>>1 logical, 5 A+1, 6 B+1, 7 A-1, 8 B-1, 9 (A==B), A (A>B), B (A<B) as 8'h01/8'h00; C-F pass A; all results wrap modulo 256, unsigned.
REQ-014 Branch conditions: 0 A==B, 1 A>B, 2 A<B, other values never taken; not taken SHALL continue at PC+2.
REQ-015 PC SHALL wrap from 8'hFF to 8'h00.
REQ-016 Cycle counts: ALU/no-op/return 3; goto/branch/call 4; store 4; load/deref 5.
REQ-017 Loads SHALL drive BUS_ADDR, then capture BUS_DATA on the second following edge; BUS_WE stays 0.
REQ-018 Stores SHALL assert BUS_WE for exactly one cycle with BUS_ADDR and BUS_DATA stable that cycle.
REQ-019 Idle SHALL hold until a request is raised; bit 0 has priority over bit 1 when both raise simultaneously.
REQ-020 Servicing interrupt n SHALL pulse ACK[n] one cycle, save the post-idle PC in RET, and load PC from ROM[8'hFF] (n=0) or ROM[8'hFE] (n=1).
REQ-021 Requests SHALL be ignored outside idle; they stay pending while held high.

Reset
REQ-022 Reset state: PC=0, A=0, B=0, RET=0, ROM_ADDRESS=0, BUS_ADDR=8'hFF, BUS_WE=0, BUS_DATA high-Z, ACK=2'b00, state FETCH.
REQ-023 Reset asserted mid-instruction SHALL abort it asynchronously; a pending store SHALL not complete.
REQ-024 First fetch SHALL be from ROM address 0 on the first edge after RESET returns high.

Configuration
REQ-025 Macro ALU_MUL_EN: defined, ALU op 2 SHALL be A*B low 8 bits; undefined, no multiplier SHALL be built and op 2 SHALL pass A.

Verification
REQ-026 Hold RESET=0 for 3 cycles, release -> ROM_ADDRESS=8'h00, BUS_WE=0, ACK=2'b00, BUS_DATA high-Z.
REQ-027 ROM: 00:8'h00,01:8'h10 (load A from 8'h10, mem=8'h07), 02:8'h01,03:8'h11 (mem=8'hFA), 04:8'h04 (A+B) -> A=8'h01 (wrap).
REQ-028 A=8'h5A then opcode 2, operand 8'hC0 -> exactly one cycle with BUS_WE=1, BUS_ADDR=8'hC0, BUS_DATA=8'h5A.
REQ-029 Goto 8'hFF with ROM[FF]=no-op -> next fetch at ROM_ADDRESS 8'h00.
REQ-030 Idle, ROM[FF]=8'h40, raise 2'b11 -> ACK=2'b01 one cycle, next fetch 8'h40; return -> fetch post-idle address.
REQ-031 A=8'h05, B=8'h06, op 8'h24, with and without ALU_MUL_EN -> A=8'h1E / A=8'h05.
